griffin_core_arbiter: RTL and testbench

- Shares one Griffin permutation core among NUM_REQ requesters using round-robin arbitration.
- Accepts a full input state from the granted requester and sequences the core through one start pulse and the done wait.
- Returns the permuted state, tagged with the requester ID, over a valid/ready response channel.
- A watchdog aborts a hung permutation and flags it as an error response.

---
 rtl/griffin_core_arbiter.sv | 165 ++++++++++++++++
 tb/tb_griffin_core_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/griffin_core_arbiter.sv
// Round-robin arbiter sharing one Griffin permutation core among NUM_REQ requesters,
// with a single outstanding request, a valid/ready response channel and a WAIT watchdog.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | scanning req_valid from rr_ptr; grant latches the input state
// START | core_enable pulse, watchdog cleared
// WAIT  | waiting for core_done or watchdog expiry
// RESP  | response held until resp_ready
module griffin_core_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int N_BITS         = 254,
    parameter int STATE_SIZE     = 3,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*STATE_SIZE*N_BITS-1:0]  req_state,
    output logic                                  resp_valid,
    input  logic                                  resp_ready,
    output logic [ID_W-1:0]                       resp_id,
    output logic [STATE_SIZE*N_BITS-1:0]          resp_state,
    output logic                                  resp_err,
    output logic                                  core_enable,
    output logic [STATE_SIZE*N_BITS-1:0]          core_in_state,
    input  logic [STATE_SIZE*N_BITS-1:0]          core_out_state,
    input  logic                                  core_done,
    output logic                                  busy
);

    localparam int SW   = STATE_SIZE * N_BITS;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [WD_W-1:0] watchdog_q, watchdog_d;
    logic            core_enable_q, core_enable_d;
    logic [SW-1:0]   core_in_state_q, core_in_state_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_err_q, resp_err_d;
    logic [ID_W-1:0] resp_id_q, resp_id_d;
    logic [SW-1:0]   resp_state_q, resp_state_d;

    logic            found;
    logic [ID_W-1:0] winner;
    int              idx;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr_q;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_id_d      = grant_id_q;
        watchdog_d      = watchdog_q;
        core_enable_d   = 1'b0;
        core_in_state_d = core_in_state_q;
        resp_valid_d    = resp_valid_q;
        resp_err_d      = resp_err_q;
        resp_id_d       = resp_id_q;
        resp_state_d    = resp_state_q;
        req_ready       = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    core_in_state_d   = req_state[int'(winner)*SW +: SW];
                    grant_id_d        = winner;
                    rr_ptr_d          = (int'(winner) == NUM_REQ - 1) ? '0 : winner + ID_W'(1);
                    core_enable_d     = 1'b1;
                    state_d           = START;
                end
            end
            START: begin
                watchdog_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // A done arriving on the final watchdog cycle still returns real data.
                if (core_done) begin
                    resp_state_d = core_out_state;
                    resp_id_d    = grant_id_q;
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else if (watchdog_q == WD_LAST) begin
                    resp_state_d = '0;
                    resp_id_d    = grant_id_q;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    watchdog_d = watchdog_q + WD_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            rr_ptr_q        <= '0;
            grant_id_q      <= '0;
            watchdog_q      <= '0;
            core_enable_q   <= 1'b0;
            core_in_state_q <= '0;
            resp_valid_q    <= 1'b0;
            resp_err_q      <= 1'b0;
            resp_id_q       <= '0;
            resp_state_q    <= '0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            grant_id_q      <= grant_id_d;
            watchdog_q      <= watchdog_d;
            core_enable_q   <= core_enable_d;
            core_in_state_q <= core_in_state_d;
            resp_valid_q    <= resp_valid_d;
            resp_err_q      <= resp_err_d;
            resp_id_q       <= resp_id_d;
            resp_state_q    <= resp_state_d;
        end
    end

    assign core_enable   = core_enable_q;
    assign core_in_state = core_in_state_q;
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign resp_id       = resp_id_q;
    assign resp_state    = resp_state_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_griffin_core_arbiter.sv
// Directed bench for griffin_core_arbiter: table of transactions plus reset/stray-done sequences,
// with a behavioural core stub that returns input+1 per element after a programmable delay.
module tb_griffin_core_arbiter;

    localparam int NR  = 4;
    localparam int NB  = 254;
    localparam int SS  = 3;
    localparam int TO  = 16;
    localparam int IDW = 2;
    localparam int SW  = SS * NB;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*SW-1:0]  req_state;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [SW-1:0]     resp_state;
    logic              resp_err;
    logic              core_enable;
    logic [SW-1:0]     core_in_state;
    logic [SW-1:0]     core_out_state;
    logic              core_done;
    logic              busy;

    logic stub_done;
    logic stray_done;
    int   stub_delay;
    int   stub_cnt;

    int errors = 0;
    int checks = 0;

    griffin_core_arbiter #(
        .NUM_REQ(NR), .N_BITS(NB), .STATE_SIZE(SS), .TIMEOUT_CYCLES(TO), .ID_W(IDW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_state(req_state),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_state(resp_state), .resp_err(resp_err),
        .core_enable(core_enable), .core_in_state(core_in_state),
        .core_out_state(core_out_state), .core_done(core_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stub: done pulse stub_delay cycles after core_enable; delay <= 0 means never.
    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (reset) begin
            stub_cnt <= 0;
        end else if (core_enable) begin
            if (stub_delay == 1) stub_done <= 1'b1;
            else if (stub_delay > 1) stub_cnt <= stub_delay - 1;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) stub_done <= 1'b1;
        end
    end

    always_comb begin
        core_out_state = '0;
        for (int j = 0; j < SS; j++)
            core_out_state[j*NB +: NB] = core_in_state[j*NB +: NB] + NB'(1);
    end

    assign core_done = stub_done | stray_done;

    function automatic logic [NB-1:0] elem(input int i, input int j);
        logic [NB-1:0] e;
        e            = '0;
        e[NB-1]      = 1'b1;
        e[NB-2 -: 8] = 8'(8'hA5 ^ i);
        e[15:0]      = 16'(i * 16 + j + 3);
        return e;
    endfunction

    function automatic logic [SW-1:0] slice_of(input int i);
        logic [SW-1:0] s;
        for (int j = 0; j < SS; j++) s[j*NB +: NB] = elem(i, j);
        return s;
    endfunction

    function automatic logic [SW-1:0] inc_of(input int i);
        logic [SW-1:0] s;
        for (int j = 0; j < SS; j++) s[j*NB +: NB] = elem(i, j) + NB'(1);
        return s;
    endfunction

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0] mask;
        int         dly;
        int         bp;
        int         id;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs[13];

    task automatic run_txn(input vec_t v);
        logic [NR-1:0] oh;
        logic [SW-1:0] exp_st;
        int cnt;
        int lat;
        oh         = NR'(1) << v.id;
        exp_st     = v.err ? '0 : inc_of(v.id);
        stub_delay = v.dly;
        req_valid  = v.mask;
        #1;
        cnt = 0;
        while (req_ready == '0 && cnt < 20) begin
            @(negedge clk); #1;
            cnt++;
        end
        chk("grant_wait", SW'(cnt), SW'(0));
        chk("req_ready", SW'(req_ready), SW'(oh));
        @(negedge clk);
        req_valid = v.mask & ~oh;
        #1;
        chk("start_enable", SW'(core_enable), SW'(1));
        chk("start_busy", SW'(busy), SW'(1));
        chk("start_ready", SW'(req_ready), SW'(0));
        chk("core_in_state", core_in_state, slice_of(v.id));
        @(negedge clk);
        lat = 1;
        chk("wait_enable", SW'(core_enable), SW'(0));
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", SW'(lat), SW'(v.lat));
        chk("resp_valid", SW'(resp_valid), SW'(1));
        chk("resp_id", SW'(resp_id), SW'(v.id));
        chk("resp_err", SW'(resp_err), SW'(v.err));
        chk("resp_state", resp_state, exp_st);
        chk("in_state_held", core_in_state, slice_of(v.id));
        if (v.bp > 0) req_valid = '1;
        for (int c = 0; c < v.bp; c++) begin
            @(negedge clk); #1;
            chk("bp_valid", SW'(resp_valid), SW'(1));
            chk("bp_id", SW'(resp_id), SW'(v.id));
            chk("bp_err", SW'(resp_err), SW'(v.err));
            chk("bp_state", resp_state, exp_st);
            chk("bp_ready", SW'(req_ready), SW'(0));
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("accept_valid", SW'(resp_valid), SW'(0));
        chk("accept_err", SW'(resp_err), SW'(0));
        chk("accept_busy", SW'(busy), SW'(0));
        req_valid = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, SW'(req_ready), SW'(0));
        chk({tag, "_resp_valid"}, SW'(resp_valid), SW'(0));
        chk({tag, "_resp_err"}, SW'(resp_err), SW'(0));
        chk({tag, "_resp_id"}, SW'(resp_id), SW'(0));
        chk({tag, "_resp_state"}, resp_state, '0);
        chk({tag, "_core_enable"}, SW'(core_enable), SW'(0));
        chk({tag, "_core_in_state"}, core_in_state, '0);
        chk({tag, "_busy"}, SW'(busy), SW'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL time_limit: simulation did not finish, errors=%0d", errors);
        $fatal(1, "time limit");
    end

    initial begin
        // mask, stub delay, backpressure cycles, expected id, err, latency from core_enable
        vecs[0]  = '{4'b1111,  5,  0, 0, 1'b0,  6};
        vecs[1]  = '{4'b1111,  5,  0, 1, 1'b0,  6};
        vecs[2]  = '{4'b1111,  5,  0, 2, 1'b0,  6};
        vecs[3]  = '{4'b1111,  5,  0, 3, 1'b0,  6};
        vecs[4]  = '{4'b1111,  5,  0, 0, 1'b0,  6};
        vecs[5]  = '{4'b0100,  5, 10, 2, 1'b0,  6};
        vecs[6]  = '{4'b0010, -1,  0, 1, 1'b1, 17};
        vecs[7]  = '{4'b0010,  3,  0, 1, 1'b0,  4};
        vecs[8]  = '{4'b1001, 16,  0, 3, 1'b0, 17};
        vecs[9]  = '{4'b1001,  2,  0, 0, 1'b0,  3};
        vecs[10] = '{4'b1010,  1,  0, 1, 1'b0,  2};
        vecs[11] = '{4'b0101,  4,  0, 2, 1'b0,  5};
        vecs[12] = '{4'b0011,  5,  0, 0, 1'b0,  6};

        for (int i = 0; i < NR; i++) req_state[i*SW +: SW] = slice_of(i);
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        stray_done = 1'b0;
        stub_delay = 5;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) run_txn(vecs[i]);

        // Stray done in IDLE must not create a response.
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stray_resp_valid", SW'(resp_valid), SW'(0));
            chk("stray_busy", SW'(busy), SW'(0));
        end

        // Reset while in WAIT; rr_ptr is 1 here so requester 2 is granted.
        stub_delay = 5;
        req_valid  = 4'b0100;
        #1;
        chk("rst_pre_grant", SW'(req_ready), SW'(4'b0100));
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_busy", SW'(busy), SW'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("midrst_no_resp", SW'(resp_valid), SW'(0));
        end
        // rr_ptr back at 0: all valid grants requester 0.
        run_txn('{4'b1111, 5, 0, 0, 1'b0, 6});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
